reorder_buffer: RTL and testbench

- Circular in-order completion buffer at the far end of the issue interface. It accepts one issued instruction per cycle (ROB_enable), hands out its tag (ROB_nextTag), and reports back-pressure (ROB_full).
- It captures results from the common data bus and retires the head entry in program order to the register file and LSB.
- On retirement of a mispredicted branch it flushes the pipeline and redirects fetch.

---
 rtl/reorder_buffer_pkg.sv | 35 +++
 rtl/reorder_buffer_entry_array.sv | 134 +++++++++++++
 rtl/reorder_buffer.sv | 191 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: sizing, tag type and the
// operation classes an entry can hold.
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int TAG_W     = $clog2(ROB_SIZE);
  localparam int CNT_W     = TAG_W + 1;
  localparam int ROB_RANGE = ROB_SIZE - 1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_STORE  = 2'd1,
    OP_BRANCH = 2'd2
  } optype_e;

  // A store never writes a register, so store takes priority if both are flagged.
  function automatic optype_e classify(input logic is_store, input logic is_branch);
    if (is_store) begin
      return OP_STORE;
    end else if (is_branch) begin
      return OP_BRANCH;
    end
    return OP_ALU;
  endfunction

  function automatic rob_tag_t tag_next(input rob_tag_t t);
    return t + TAG_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// Entry storage for the reorder buffer: one issue write port, one CDB write
// port, a retire clear, a global flush and three read ports.
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_all,
  input  logic             issue_we,
  input  logic [TAG_W-1:0] issue_idx,
  input  logic [4:0]       issue_rd,
  input  logic [1:0]       issue_op,
  input  logic             cdb_we,
  input  logic [TAG_W-1:0] cdb_idx,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target,
  input  logic             retire,
  input  logic [TAG_W-1:0] head_idx,
  input  logic [TAG_W-1:0] q1_idx,
  input  logic [TAG_W-1:0] q2_idx,
  output logic             head_busy,
  output logic             head_ready,
  output logic [4:0]       head_rd,
  output logic [1:0]       head_op,
  output logic             head_mispredict,
  output logic [31:0]      head_value,
  output logic [31:0]      head_target,
  output logic             q1_ready,
  output logic [31:0]      q1_value,
  output logic             q2_ready,
  output logic [31:0]      q2_value
);

  logic [ROB_SIZE-1:0] busy_all;
  logic [ROB_SIZE-1:0] ready_all;
  logic [ROB_SIZE-1:0] misp_all;
  logic [4:0]          rd_all     [ROB_SIZE];
  logic [1:0]          op_all     [ROB_SIZE];
  logic [31:0]         value_all  [ROB_SIZE];
  logic [31:0]         target_all [ROB_SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      logic        busy_q, busy_d;
      logic        ready_q, ready_d;
      logic        misp_q, misp_d;
      logic [4:0]  rd_q, rd_d;
      logic [1:0]  op_q, op_d;
      logic [31:0] value_q, value_d;
      logic [31:0] target_q, target_d;
      logic        issue_sel, cdb_sel, retire_sel;

      assign issue_sel  = issue_we && (issue_idx == TAG_W'(gi));
      assign cdb_sel    = cdb_we && (cdb_idx == TAG_W'(gi)) && busy_q;
      assign retire_sel = retire && (head_idx == TAG_W'(gi));

      always_comb begin
        busy_d   = busy_q;
        ready_d  = ready_q;
        misp_d   = misp_q;
        rd_d     = rd_q;
        op_d     = op_q;
        value_d  = value_q;
        target_d = target_q;
        // Flush dominates everything, including a same-cycle issue.
        if (flush_all) begin
          busy_d  = FALSE;
          ready_d = FALSE;
        end else begin
          if (retire_sel) begin
            busy_d = FALSE;
          end
          if (issue_sel) begin
            busy_d  = TRUE;
            ready_d = FALSE;
            misp_d  = FALSE;
            rd_d    = issue_rd;
            op_d    = issue_op;
          end
          if (cdb_sel) begin
            ready_d  = TRUE;
            value_d  = cdb_value;
            misp_d   = cdb_mispredict;
            target_d = cdb_target;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_q   <= FALSE;
          ready_q  <= FALSE;
          misp_q   <= FALSE;
          rd_q     <= '0;
          op_q     <= OP_ALU;
          value_q  <= '0;
          target_q <= '0;
        end else begin
          busy_q   <= busy_d;
          ready_q  <= ready_d;
          misp_q   <= misp_d;
          rd_q     <= rd_d;
          op_q     <= op_d;
          value_q  <= value_d;
          target_q <= target_d;
        end
      end

      assign busy_all[gi]   = busy_q;
      assign ready_all[gi]  = ready_q;
      assign misp_all[gi]   = misp_q;
      assign rd_all[gi]     = rd_q;
      assign op_all[gi]     = op_q;
      assign value_all[gi]  = value_q;
      assign target_all[gi] = target_q;
    end
  endgenerate

  assign head_busy       = busy_all[head_idx];
  assign head_ready      = ready_all[head_idx];
  assign head_rd         = rd_all[head_idx];
  assign head_op         = op_all[head_idx];
  assign head_mispredict = misp_all[head_idx];
  assign head_value      = value_all[head_idx];
  assign head_target     = target_all[head_idx];

  assign q1_ready = ready_all[q1_idx];
  assign q1_value = value_all[q1_idx];
  assign q2_ready = ready_all[q2_idx];
  assign q2_value = value_all[q2_idx];

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order completion buffer: allocates tags at issue, captures CDB
// results, retires the head in program order and flushes on a mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             ROB_enable,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_store,
  input  logic             issue_is_branch,
  output logic             ROB_full,
  output logic [TAG_W-1:0] ROB_nextTag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_value1,
  output logic [31:0]      query_value2,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_value,
  output logic             store_commit,
  output logic [TAG_W-1:0] store_tag,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  rob_tag_t         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             commit_valid_q, commit_valid_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  rob_tag_t         commit_tag_q, commit_tag_d;
  logic [31:0]      commit_value_q, commit_value_d;
  logic             store_commit_q, store_commit_d;
  rob_tag_t         store_tag_q, store_tag_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  logic             head_busy, head_ready, head_mispredict;
  logic [4:0]       head_rd;
  logic [1:0]       head_op;
  logic [31:0]      head_value, head_target;
  logic             q1_ready, q2_ready;
  logic [31:0]      q1_value, q2_value;
  logic             head_is_store, head_is_branch;
  logic             do_issue, do_commit, do_flush, cdb_we;
  logic             cdb_hit1, cdb_hit2;

  assign head_is_store  = (head_op == OP_STORE);
  assign head_is_branch = (head_op == OP_BRANCH);

  // Full status comes from the pre-edge count, so a commit never frees a slot early.
  assign ROB_full    = (count_q == CNT_W'(ROB_SIZE));
  assign ROB_nextTag = tail_q;

  assign do_commit = rdy && head_busy && head_ready;
  assign do_flush  = do_commit && head_is_branch && head_mispredict;
  assign do_issue  = rdy && ROB_enable && !ROB_full && !do_flush;
  assign cdb_we    = rdy && cdb_valid;

  rob_entry_array u_entries (
    .clk             (clk),
    .rst             (rst),
    .flush_all       (do_flush),
    .issue_we        (do_issue),
    .issue_idx       (tail_q),
    .issue_rd        (issue_rd),
    .issue_op        (classify(issue_is_store, issue_is_branch)),
    .cdb_we          (cdb_we),
    .cdb_idx         (cdb_tag),
    .cdb_value       (cdb_value),
    .cdb_mispredict  (cdb_mispredict),
    .cdb_target      (cdb_target),
    .retire          (do_commit),
    .head_idx        (head_q),
    .q1_idx          (query_tag1),
    .q2_idx          (query_tag2),
    .head_busy       (head_busy),
    .head_ready      (head_ready),
    .head_rd         (head_rd),
    .head_op         (head_op),
    .head_mispredict (head_mispredict),
    .head_value      (head_value),
    .head_target     (head_target),
    .q1_ready        (q1_ready),
    .q1_value        (q1_value),
    .q2_ready        (q2_ready),
    .q2_value        (q2_value)
  );

  // Operand lookups see a result on the CDB in the same cycle it is broadcast.
  assign cdb_hit1     = cdb_valid && (cdb_tag == query_tag1);
  assign cdb_hit2     = cdb_valid && (cdb_tag == query_tag2);
  assign query_ready1 = q1_ready || cdb_hit1;
  assign query_ready2 = q2_ready || cdb_hit2;
  assign query_value1 = cdb_hit1 ? cdb_value : q1_value;
  assign query_value2 = cdb_hit2 ? cdb_value : q2_value;

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = FALSE;
    commit_rd_d    = commit_rd_q;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;
    store_commit_d = FALSE;
    store_tag_d    = store_tag_q;
    flush_d        = FALSE;
    flush_pc_d     = flush_pc_q;

    if (do_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_issue) begin
        tail_d = tag_next(tail_q);
      end
      if (do_commit) begin
        head_d = tag_next(head_q);
      end
      count_d = count_q + CNT_W'(do_issue) - CNT_W'(do_commit);
    end

    if (do_commit) begin
      if ((|head_rd) && !head_is_store) begin
        commit_valid_d = TRUE;
        commit_rd_d    = head_rd;
        commit_tag_d   = head_q;
        commit_value_d = head_value;
      end
      if (head_is_store) begin
        store_commit_d = TRUE;
        store_tag_d    = head_q;
      end
      if (do_flush) begin
        flush_d    = TRUE;
        flush_pc_d = head_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= FALSE;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      store_commit_q <= FALSE;
      store_tag_q    <= '0;
      flush_q        <= FALSE;
      flush_pc_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
      store_commit_q <= store_commit_d;
      store_tag_q    <= store_tag_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Pulses are suppressed while the pipeline is stalled.
  assign commit_valid = commit_valid_q && rdy;
  assign store_commit = store_commit_q && rdy;
  assign flush        = flush_q && rdy;
  assign commit_rd    = commit_rd_q;
  assign commit_tag   = commit_tag_q;
  assign commit_value = commit_value_q;
  assign store_tag    = store_tag_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer against a queue-based model
// of in-order allocation, writeback, retirement and flush.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic             clk = 1'b0;
  logic             rst, rdy, ROB_enable, issue_is_store, issue_is_branch;
  logic [4:0]       issue_rd;
  logic             ROB_full;
  logic [TAG_W-1:0] ROB_nextTag;
  logic             cdb_valid, cdb_mispredict;
  logic [TAG_W-1:0] cdb_tag, query_tag1, query_tag2;
  logic [31:0]      cdb_value, cdb_target;
  logic             query_ready1, query_ready2;
  logic [31:0]      query_value1, query_value2;
  logic             commit_valid, store_commit, flush;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_tag, store_tag;
  logic [31:0]      commit_value, flush_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ROB_enable(ROB_enable),
    .issue_rd(issue_rd), .issue_is_store(issue_is_store), .issue_is_branch(issue_is_branch),
    .ROB_full(ROB_full), .ROB_nextTag(ROB_nextTag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_value(commit_value), .store_commit(store_commit), .store_tag(store_tag),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          rd;
    bit          st;
    bit          br;
    bit          done;
    bit          misp;
    logic [31:0] val;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  int          m_next;
  logic        m_cv, m_sc, m_fl;
  logic [4:0]  m_crd;
  logic [3:0]  m_ctag, m_stag;
  logic [31:0] m_cval, m_fpc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  function automatic int find(input int t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_next = 0;
    m_cv = 0; m_sc = 0; m_fl = 0;
    m_crd = 0; m_ctag = 0; m_stag = 0; m_cval = 0; m_fpc = 0;
  endtask

  task automatic clear_inputs();
    rdy = 1; ROB_enable = 0; issue_rd = 0; issue_is_store = 0; issue_is_branch = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_mispredict = 0; cdb_target = 0;
    query_tag1 = 0; query_tag2 = 0;
  endtask

  task automatic chk_query(input string nm, input int t, input logic r, input logic [31:0] v);
    int  i;
    bit  er;
    logic [31:0] ev;
    i = find(t);
    if (cdb_valid && cdb_tag == TAG_W'(t)) begin
      er = 1; ev = cdb_value;
    end else if (i >= 0) begin
      er = q[i].done; ev = q[i].val;
    end else begin
      return;
    end
    chk({nm, "_ready"}, r, er);
    if (er) chk({nm, "_value"}, v, ev);
  endtask

  // One clock of the reference: retire the oldest finished entry, record the
  // broadcast result, then append the new instruction if there was room.
  task automatic model_update();
    ent_t h;
    bit   com, fl, full_pre;
    int   i;
    m_cv = 0; m_sc = 0; m_fl = 0;
    if (!rdy) return;
    full_pre = (q.size() == ROB_SIZE);
    com = (q.size() > 0) && q[0].done;
    fl = 0;
    if (com) h = q[0];
    if (cdb_valid) begin
      i = find(int'(cdb_tag));
      if (i >= 0) begin
        q[i].done = 1; q[i].val = cdb_value; q[i].misp = cdb_mispredict; q[i].tgt = cdb_target;
      end
    end
    if (com) begin
      void'(q.pop_front());
      if (h.rd != 0 && !h.st) begin
        m_cv = 1; m_crd = 5'(h.rd); m_ctag = 4'(h.tag); m_cval = h.val;
      end
      if (h.st) begin
        m_sc = 1; m_stag = 4'(h.tag);
      end
      if (h.br && h.misp) begin
        m_fl = 1; m_fpc = h.tgt; fl = 1;
        q.delete(); m_next = 0;
      end
    end
    if (!fl && ROB_enable && !full_pre) begin
      ent_t e;
      e.tag = m_next; e.rd = int'(issue_rd); e.st = issue_is_store;
      e.br = issue_is_branch && !issue_is_store;
      e.done = 0; e.misp = 0; e.val = 0; e.tgt = 0;
      q.push_back(e);
      m_next = (m_next + 1) % ROB_SIZE;
    end
  endtask

  task automatic step();
    #1;
    chk("full", ROB_full, q.size() == ROB_SIZE);
    chk("next_tag", ROB_nextTag, m_next);
    chk_query("query1", int'(query_tag1), query_ready1, query_value1);
    chk_query("query2", int'(query_tag2), query_ready2, query_value2);
    model_update();
    @(posedge clk);
    #1;
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_rd", commit_rd, m_crd);
    chk("commit_tag", commit_tag, m_ctag);
    chk("commit_value", commit_value, m_cval);
    chk("store_commit", store_commit, m_sc);
    chk("store_tag", store_tag, m_stag);
    chk("flush", flush, m_fl);
    chk("flush_pc", flush_pc, m_fpc);
    $display("cycle: rdy=%0b en=%0b cdb=%0b/%0d cv=%0b rd=%0d sc=%0b fl=%0b occ=%0d",
             rdy, ROB_enable, cdb_valid, cdb_tag, commit_valid, commit_rd, store_commit, flush, q.size());
  endtask

  task automatic set_issue(input int rd, input bit st, input bit br);
    ROB_enable = 1; issue_rd = 5'(rd); issue_is_store = st; issue_is_branch = br;
    cdb_valid = 0;
  endtask

  task automatic set_cdb(input int t, input logic [31:0] v, input bit mp, input logic [31:0] tg);
    ROB_enable = 0; cdb_valid = 1; cdb_tag = TAG_W'(t); cdb_value = v;
    cdb_mispredict = mp; cdb_target = tg;
  endtask

  task automatic async_reset();
    clear_inputs();
    @(negedge clk);
    #1 rst = 0;
    #1;
    model_reset();
    chk("rst_full", ROB_full, 0);
    chk("rst_next_tag", ROB_nextTag, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_store_commit", store_commit, 0);
    chk("rst_flush", flush, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, t;
    clear_inputs();
    rst = 0;
    model_reset();
    #3;
    chk("init_full", ROB_full, 0);
    chk("init_next_tag", ROB_nextTag, 0);
    chk("init_commit_valid", commit_valid, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;

    // Reset in the middle of a stream discards everything.
    for (int i = 0; i < 3; i++) begin set_issue(i + 1, 0, 0); step(); end
    chk("three_issued_tag", ROB_nextTag, 3);
    async_reset();
    set_issue(7, 0, 0);
    #1 chk("first_tag_after_reset", ROB_nextTag, 0);
    step();
    chk("tag_after_one_issue", ROB_nextTag, 1);
    async_reset();

    // Fill to capacity, then an extra request must be dropped.
    for (int i = 0; i < ROB_SIZE; i++) begin set_issue(i + 1, 0, 0); step(); end
    chk("full_after_16", ROB_full, 1);
    set_issue(17, 0, 0);
    step();
    chk("full_after_17th", ROB_full, 1);
    chk("next_tag_after_17th", ROB_nextTag, 0);
    async_reset();

    // Out-of-order writeback, in-order retirement.
    set_issue(5, 0, 0); step();
    set_issue(6, 0, 0); step();
    set_cdb(1, 32'hAA, 0, 0); step();
    set_cdb(0, 32'h55, 0, 0); step();
    chk("no_commit_same_edge", commit_valid, 0);
    clear_inputs(); step();
    chk("first_commit_rd", commit_rd, 5);
    chk("first_commit_value", commit_value, 32'h55);
    step();
    chk("second_commit_rd", commit_rd, 6);
    chk("second_commit_value", commit_value, 32'hAA);

    // CDB bypass on operand lookup.
    set_issue(8, 0, 0); step();
    set_issue(9, 0, 0); step();
    set_cdb(3, 32'h1234, 0, 0);
    query_tag1 = 3; query_tag2 = 2;
    #1;
    chk("bypass_ready", query_ready1, 1);
    chk("bypass_value", query_value1, 32'h1234);
    chk("pending_not_ready", query_ready2, 0);
    step();
    set_cdb(2, 32'h77, 0, 0); step();
    clear_inputs();
    repeat (3) step();

    // Store retirement.
    set_issue(0, 1, 0); step();
    set_cdb(4, 32'h9, 0, 0); step();
    clear_inputs(); step();
    chk("store_commit_pulse", store_commit, 1);
    chk("store_commit_tag", store_tag, 4);
    chk("store_no_reg_write", commit_valid, 0);
    step();
    chk("store_pulse_one_cycle", store_commit, 0);
    async_reset();

    // Mispredicted branch with younger entries behind it.
    set_issue(3, 0, 0); step();
    set_issue(4, 0, 0); step();
    set_issue(1, 0, 1); step();
    for (int i = 0; i < 3; i++) begin set_issue(10 + i, 0, 0); step(); end
    set_cdb(0, 32'h10, 0, 0); step();
    set_cdb(1, 32'h20, 0, 0); step();
    set_cdb(2, 32'h44, 1, 32'h100); step();
    clear_inputs();
    set_issue(20, 0, 0);
    step();
    chk("branch_flush", flush, 1);
    chk("branch_flush_pc", flush_pc, 32'h100);
    chk("branch_commit_valid", commit_valid, 1);
    chk("branch_commit_rd", commit_rd, 1);
    chk("branch_link_value", commit_value, 32'h44);
    clear_inputs();
    #1;
    chk("flush_next_tag", ROB_nextTag, 0);
    chk("flush_not_full", ROB_full, 0);
    step();

    // Stall holds state.
    rdy = 0; set_issue(2, 0, 0); step();
    rdy = 1; set_issue(2, 0, 0); step();
    set_cdb(0, 32'hBEEF, 0, 0); step();
    clear_inputs(); rdy = 0;
    repeat (2) step();
    rdy = 1; step();
    chk("commit_after_stall", commit_value, 32'hBEEF);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) async_reset();
      rdy             = ($urandom_range(0, 9) != 0);
      ROB_enable      = ($urandom_range(0, 2) != 0);
      issue_rd        = 5'($urandom_range(0, 31));
      issue_is_store  = ($urandom_range(0, 4) == 0);
      issue_is_branch = !issue_is_store && ($urandom_range(0, 3) == 0);
      cdb_value       = $urandom;
      cdb_target      = $urandom;
      cdb_mispredict  = ($urandom_range(0, 2) == 0);
      cdb_valid       = 0;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        cdb_valid = 1;
        cdb_tag = TAG_W'(q[k].tag);
      end else if ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, ROB_SIZE - 1);
        if (find(t) < 0 && !(ROB_enable && t == m_next)) begin
          cdb_valid = 1;
          cdb_tag = TAG_W'(t);
        end
      end
      query_tag1 = TAG_W'($urandom_range(0, ROB_SIZE - 1));
      query_tag2 = TAG_W'($urandom_range(0, ROB_SIZE - 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
